cim_bus_arb: RTL
================

CIM_BUS_ARB -- requirements
Module: cim_bus_arb

Interface
REQ-001 The module SHALL expose parameter TIMEOUT_CYC, default 255, giving the maximum busy-wait cycles before abort (used only with CIM_BUS_ARB_TIMEOUT_EN).
REQ-002 The module SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 i_req  input  2  per-requester access request; bit0 = write controller, bit1 = compute/read controller.
REQ-006 i_cim_sel  input  4  target CIM per requester, [1:0] for req0 and [3:2] for req1.
REQ-007 i_rw_n  input  2  per-requester direction: 1 = read, 0 = write.
REQ-008 i_op_sel  input  4  per-requester bank/half select, 2 bits each.
REQ-009 i_op_adr  input  24  per-requester address, 12 bits each: [11:4] row, [3:0] column.
REQ-010 i_com_busy  input  4  per-CIM busy flag.
REQ-011 o_gnt  output  2  one-cycle pulse when a requester's command is captured.
REQ-012 o_done  output  2  one-cycle pulse when that requester's access completes.
REQ-013 o_err  output  2  qualifies o_done; high means the access timed out.
REQ-014 o_cim_cs_n  output  4  active-low CIM chip selects.
REQ-015 o_op_sel, o_op_adr, o_op_rw_n  output  2/12/1  shared CIM command bus.
REQ-016 o_owner  output  1  index of the current or last-granted requester.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, GUARD and WAIT, encoded per the shared package.
REQ-018 In IDLE, requester k SHALL be eligible only when i_req[k]=1 and i_com_busy[its cim_sel]=0.
REQ-019 Among eligible requesters, the winner SHALL be picked round-robin: the requester not equal to o_owner wins a tie.
REQ-020 On a win in IDLE, the FSM SHALL latch the winner's cim_sel, rw_n, op_sel and op_adr, pulse o_gnt[k], update o_owner, and go to ISSUE.
REQ-021 ISSUE SHALL drive o_cim_cs_n[sel]=0 for exactly one cycle with the latched bus values, then go to GUARD.
REQ-022 GUARD SHALL deassert all chip selects, last one cycle unconditionally, then go to WAIT.
REQ-023 WAIT SHALL poll i_com_busy[sel]; when it is 0, the FSM SHALL pulse o_done[owner] with o_err=0 and return to IDLE.
REQ-024 The minimum access SHALL take 4 cycles from grant to done, and a new grant is allowed in the IDLE cycle following done.
REQ-025 The o_op_* outputs SHALL hold the latched values until the next grant.
REQ-026 The o_cim_cs_n outputs SHALL be 4'b1111 in every state except ISSUE.
REQ-027 A request withdrawn before its grant SHALL be ignored without side effects.
REQ-028 Requester inputs SHALL be sampled only in IDLE, so changes after grant have no effect.
REQ-029 If both requesters target the same CIM, only one SHALL be granted, with the other served round-robin afterwards.
REQ-030 If the target CIM is busy, that requester SHALL wait in IDLE with no grant while the other may proceed.
REQ-031 A cim_sel value SHALL always be in range, and wrap-around of the 2-bit index is not possible.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL set state=IDLE, o_cim_cs_n=4'b1111, o_op_rw_n=1, o_op_sel=0, o_op_adr=0, o_gnt=0, o_done=0, o_err=0, o_owner=1 (so req0 wins the first tie).
REQ-033 Reset asserted mid-access SHALL abort the access with no o_done pulse.

Configuration
REQ-034 With macro CIM_BUS_ARB_TIMEOUT_EN defined, a counter SHALL count WAIT cycles, and when it reaches TIMEOUT_CYC it SHALL pulse o_done[owner] with o_err[owner]=1 and return to IDLE.
REQ-035 Without CIM_BUS_ARB_TIMEOUT_EN, WAIT SHALL be unbounded, the counter SHALL be absent, and o_err SHALL be tied to 0.

Structure
REQ-036 The shared package cim_pkg SHALL hold the state encoding, the CIM count (4), the address widths (row 8, column 4) and the default TIMEOUT_CYC.
REQ-037 A sub-module cim_rr_pick SHALL implement the 2-way round-robin eligibility pick combinationally.

Verification
REQ-038 Single request: req0 writes CIM2 at adr 0x123 with busy low -> o_gnt[0] at T, o_cim_cs_n=4'b1011 at T+1, o_done[0] at T+3.
REQ-039 Simultaneous request: both requesters request after reset -> req0 granted first, req1 granted the cycle after req0's done, and o_owner alternates 0, 1.
REQ-040 Busy target: CIM1 busy for 10 cycles, req1 targets CIM1 and req0 targets CIM3 -> req0 granted immediately, and req1 granted only once busy[1]=0.
REQ-041 Reset mid-access: rst asserted during WAIT -> next cycle all cs_n=1, state IDLE, and no o_done.
REQ-042 Timeout: with TIMEOUT_EN defined, TIMEOUT_CYC=8 and busy held high -> o_done=1 with o_err=1 exactly 8 WAIT cycles after entry, and the FSM back in IDLE.

Source files
------------

// File: rtl/cim_pkg.sv
// Shared definitions for the CIM bus arbiter: FSM encoding, CIM count,
// address field widths, command-bus field widths and the default abort timeout.
package cim_pkg;

    localparam int CIM_NUM         = 4;
    localparam int CIM_SEL_W       = 2;
    localparam int ROW_W           = 8;
    localparam int COL_W           = 4;
    localparam int ADR_W           = ROW_W + COL_W;
    localparam int OPSEL_W         = 2;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } arb_state_t;

    // Active-low chip-select vector with only the selected CIM driven low.
    function automatic logic [CIM_NUM-1:0] cs_n_for(input logic [CIM_SEL_W-1:0] sel);
        logic [CIM_NUM-1:0] one_hot;
        one_hot      = '0;
        one_hot[sel] = 1'b1;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/cim_rr_pick.sv
// Two-way round-robin pick: a lone eligible requester wins outright; when both
// are eligible the one that did not own the bus last time wins.
module cim_rr_pick (
    input  logic [1:0] elig,
    input  logic       last_owner,
    output logic       valid,
    output logic       winner
);

    // Pure combinational selection; no state lives here.
    always_comb begin
        valid  = |elig;
        winner = 1'b0;
        case (elig)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_owner;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/cim_bus_arb.sv
// Arbiter sharing one CIM command bus between a write controller (requester 0)
// and a compute/read controller (requester 1). An access is a one-cycle chip
// select (ISSUE), a one-cycle guard gap (GUARD) and a busy poll (WAIT).
// Optional feature: define CIM_BUS_ARB_TIMEOUT_EN to abort WAIT after
// TIMEOUT_CYC cycles with o_err set; otherwise WAIT is unbounded and o_err is 0.
module cim_bus_arb
    import cim_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             i_req,
    input  logic [2*CIM_SEL_W-1:0] i_cim_sel,
    input  logic [1:0]             i_rw_n,
    input  logic [2*OPSEL_W-1:0]   i_op_sel,
    input  logic [2*ADR_W-1:0]     i_op_adr,
    input  logic [CIM_NUM-1:0]     i_com_busy,
    output logic [1:0]             o_gnt,
    output logic [1:0]             o_done,
    output logic [1:0]             o_err,
    output logic [CIM_NUM-1:0]     o_cim_cs_n,
    output logic [OPSEL_W-1:0]     o_op_sel,
    output logic [ADR_W-1:0]       o_op_adr,
    output logic                   o_op_rw_n,
    output logic                   o_owner
);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [CIM_SEL_W-1:0] sel_q;
    logic [CIM_SEL_W-1:0] req_sel0;
    logic [CIM_SEL_W-1:0] req_sel1;
    logic [1:0]           elig;
    logic                 pick_valid;
    logic                 pick_winner;
    logic                 win;
    logic                 in_wait;
    logic                 busy_tgt;
    logic                 done_ok;
    logic                 done_to;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("cim_bus_arb: TIMEOUT_CYC must be at least 1");
    end

    assign req_sel0 = i_cim_sel[CIM_SEL_W-1:0];
    assign req_sel1 = i_cim_sel[2*CIM_SEL_W-1:CIM_SEL_W];
    assign elig[0]  = i_req[0] & ~i_com_busy[req_sel0];
    assign elig[1]  = i_req[1] & ~i_com_busy[req_sel1];

    cim_rr_pick u_pick (
        .elig       (elig),
        .last_owner (o_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign win      = (state_q == ST_IDLE) & pick_valid & ~rst;
    assign in_wait  = (state_q == ST_WAIT);
    assign busy_tgt = i_com_busy[sel_q];
    assign done_ok  = in_wait & ~busy_tgt;

`ifdef CIM_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt_q;

    // Count cycles spent in WAIT; cleared whenever the FSM is anywhere else.
    always_ff @(posedge clk) begin
        if (rst || !in_wait) begin
            wait_cnt_q <= '0;
        end else if (wait_cnt_q != CNT_W'(TIMEOUT_CYC)) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign done_to = in_wait & busy_tgt & (wait_cnt_q == CNT_W'(TIMEOUT_CYC));

    // Error flag qualifies the done pulse of an aborted access.
    always_comb begin
        o_err = '0;
        if (done_to && !rst) o_err[o_owner] = 1'b1;
    end
`else
    assign done_to = 1'b0;
    assign o_err   = '0;
`endif

    // State register; reset drops any access in flight back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state sequencing: grant, one select cycle, one guard cycle, busy poll.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_GUARD;
            ST_GUARD: state_d = ST_WAIT;
            ST_WAIT:  if (done_ok || done_to) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Capture the winner's command at grant and hold it until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            o_op_sel  <= '0;
            o_op_adr  <= '0;
            o_op_rw_n <= 1'b1;
            o_owner   <= 1'b1;
        end else if (state_q == ST_IDLE && pick_valid) begin
            sel_q     <= pick_winner ? req_sel1 : req_sel0;
            o_op_sel  <= pick_winner ? i_op_sel[2*OPSEL_W-1:OPSEL_W] : i_op_sel[OPSEL_W-1:0];
            o_op_adr  <= pick_winner ? i_op_adr[2*ADR_W-1:ADR_W] : i_op_adr[ADR_W-1:0];
            o_op_rw_n <= i_rw_n[pick_winner];
            o_owner   <= pick_winner;
        end
    end

    // Grant/done pulses and chip selects, all silenced while reset is held.
    always_comb begin
        o_gnt      = '0;
        o_done     = '0;
        o_cim_cs_n = '1;
        if (win) o_gnt[pick_winner] = 1'b1;
        if (!rst && (done_ok || done_to)) o_done[o_owner] = 1'b1;
        if (!rst && state_q == ST_ISSUE) o_cim_cs_n = cs_n_for(sel_q);
    end

endmodule
